// File: rtl/mips_multicycle_main_fsm.sv
// Moore main control FSM for the multicycle MIPS datapath.
// Define MIPS_FSM_ADDI_EN to add the ADDIEX/ADDIWB path for addi.
module mips_multicycle_main_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic [1:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       IorD,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       PCEn,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   state_t state_q, state_d;

   logic ir_write, mem_write, reg_write, pc_write, branch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = FETCH;
      ALUOp     = 2'b00;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      PCSrc     = 2'b00;
      IorD      = 1'b0;
      MemtoReg  = 1'b0;
      RegDst    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
      case (state_q)
         FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            ALUSrcB  = 2'b01;
            state_d  = DECODE;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
`ifdef MIPS_FSM_ADDI_EN
               OP_ADDI:      state_d = ADDIEX;
`endif
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            // opcode is re-sampled here; anything but lw/sw abandons the access
            if (opcode == OP_LW)      state_d = MEMREAD;
            else if (opcode == OP_SW) state_d = MEMWRITE;
            else                      state_d = FETCH;
         end
         MEMREAD: begin
            IorD    = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            MemtoReg  = 1'b1;
            reg_write = 1'b1;
         end
         MEMWRITE: begin
            IorD      = 1'b1;
            mem_write = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         ALUWB: begin
            RegDst    = 1'b1;
            reg_write = 1'b1;
         end
         BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
`ifdef MIPS_FSM_ADDI_EN
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
         end
`endif
         JUMP: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   // Write strobes are held off while rst is high so an aborted instruction commits nothing
   assign IRWrite  = ir_write  & ~rst;
   assign MemWrite = mem_write & ~rst;
   assign RegWrite = reg_write & ~rst;
   assign PCWrite  = pc_write  & ~rst;
   assign Branch   = branch    & ~rst;
   assign PCEn     = (pc_write | (branch & zero)) & ~rst;
   assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_main_fsm.sv
// Randomized bench for mips_multicycle_main_fsm: per-instruction state path model
// plus a per-state output table, with literal state sequences for directed opcodes.
module tb_mips_multicycle_main_fsm;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic clk, rst, zero;
   logic [5:0] opcode;
   logic [1:0] ALUOp, ALUSrcB, PCSrc;
   logic ALUSrcA, IorD, MemtoReg, RegDst, IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn;
   logic [3:0] state;

   mips_multicycle_main_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .IRWrite(IRWrite),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .PCWrite(PCWrite),
      .Branch(Branch), .PCEn(PCEn), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_state;
   logic [3:0] path_q[$];
   logic [3:0] lit_seq[$];
   logic [5:0] instr_op;
   logic [5:0] dir_ops[$];
   logic       checking = 1'b0;
   logic       rst_exec_pending = 1'b0;

   // {ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemtoReg, RegDst, IRWrite, MemWrite, RegWrite, PCWrite, Branch}
   function automatic logic [14:0] tbl(input logic [3:0] s);
      logic [1:0] aop = 2'b00, srcb = 2'b00, pcs = 2'b00;
      logic sa = 0, iord = 0, m2r = 0, rd = 0, irw = 0, mw = 0, rw = 0, pcw = 0, br = 0;
      case (s)
         4'd0:  begin irw = 1; pcw = 1; srcb = 2'b01; end
         4'd1:  srcb = 2'b11;
         4'd2:  begin sa = 1; srcb = 2'b10; end
         4'd3:  iord = 1;
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin iord = 1; mw = 1; end
         4'd6:  begin sa = 1; aop = 2'b10; end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
`ifdef MIPS_FSM_ADDI_EN
         4'd9:  begin sa = 1; srcb = 2'b10; end
         4'd10: rw = 1;
`endif
         4'd11: begin pcs = 2'b10; pcw = 1; end
         default: ;
      endcase
      return {aop, sa, srcb, pcs, iord, m2r, rd, irw, mw, rw, pcw, br};
   endfunction

   // States an instruction visits after DECODE, by opcode
   task automatic load_path(input logic [5:0] op);
      path_q.delete();
      case (op)
         OP_LW:    begin path_q.push_back(4'd2); path_q.push_back(4'd3); path_q.push_back(4'd4); end
         OP_SW:    begin path_q.push_back(4'd2); path_q.push_back(4'd5); end
         OP_RTYPE: begin path_q.push_back(4'd6); path_q.push_back(4'd7); end
         OP_BEQ:   path_q.push_back(4'd8);
         OP_J:     path_q.push_back(4'd11);
`ifdef MIPS_FSM_ADDI_EN
         OP_ADDI:  begin path_q.push_back(4'd9); path_q.push_back(4'd10); end
`endif
         default: ;
      endcase
   endtask

   task automatic push_lit(input logic [5:0] op);
      lit_seq.push_back(4'd0);
      lit_seq.push_back(4'd1);
      case (op)
         OP_LW:    begin lit_seq.push_back(4'd2); lit_seq.push_back(4'd3); lit_seq.push_back(4'd4); end
         OP_SW:    begin lit_seq.push_back(4'd2); lit_seq.push_back(4'd5); end
         OP_RTYPE: begin lit_seq.push_back(4'd6); lit_seq.push_back(4'd7); end
         OP_BEQ:   lit_seq.push_back(4'd8);
         OP_J:     lit_seq.push_back(4'd11);
`ifdef MIPS_FSM_ADDI_EN
         OP_ADDI:  begin lit_seq.push_back(4'd9); lit_seq.push_back(4'd10); end
`endif
         default: ;
      endcase
   endtask

   function automatic logic [5:0] rand_op();
      case ($urandom_range(0, 6))
         0: return OP_RTYPE;
         1: return OP_LW;
         2: return OP_SW;
         3: return OP_BEQ;
         4: return OP_ADDI;
         5: return OP_J;
         default: return 6'($urandom);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      if (rst) begin
         exp_state = 4'd0;
         path_q.delete();
      end else if (exp_state == 4'd0) begin
         exp_state = 4'd1;
      end else begin
         if (exp_state == 4'd1) load_path(opcode);
         exp_state = (path_q.size() > 0) ? path_q.pop_front() : 4'd0;
      end
      #1;
      if (exp_state == 4'd0) begin
         if (dir_ops.size() > 0) begin
            instr_op = dir_ops.pop_front();
            push_lit(instr_op);
         end else begin
            instr_op = rand_op();
         end
      end
      opcode = (exp_state == 4'd1 || exp_state == 4'd2) ? instr_op : 6'($urandom);
      zero   = 1'($urandom);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         logic [14:0] e, a;
         logic e_pcen;
         e = tbl(exp_state);
         if (rst) e[4:0] = 5'b0;
         e_pcen = e[1] | (e[0] & zero);
         a = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemtoReg, RegDst, IRWrite, MemWrite, RegWrite, PCWrite, Branch};
         checks++;
         if (state !== exp_state) begin
            errors++;
            $display("FAIL state: got %0d expected %0d (rst=%0b)", state, exp_state, rst);
         end
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs in state %0d: got %b expected %b", exp_state, a, e);
         end
         checks++;
         if (PCEn !== e_pcen) begin
            errors++;
            $display("FAIL PCEn in state %0d zero=%0b: got %b expected %b", exp_state, zero, PCEn, e_pcen);
         end
         checks++;
         if (ALUOp === 2'b11) begin
            errors++;
            $display("FAIL ALUOp illegal: got %b expected not 11", ALUOp);
         end
         if (lit_seq.size() > 0) begin
            logic [3:0] l;
            l = lit_seq.pop_front();
            checks++;
            if (state !== l) begin
               errors++;
               $display("FAIL literal sequence: got state %0d expected %0d", state, l);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; opcode = 6'd0; zero = 1'b0;
      exp_state = 4'd0; instr_op = OP_RTYPE;
      dir_ops.push_back(OP_LW);
      dir_ops.push_back(OP_SW);
      dir_ops.push_back(OP_RTYPE);
      dir_ops.push_back(OP_BEQ);
      dir_ops.push_back(OP_BEQ);
      dir_ops.push_back(OP_J);
      dir_ops.push_back(OP_ADDI);
      dir_ops.push_back(6'b111111);
      #2 checking = 1'b1;
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || ALUSrcB !== 2'b01) begin
         errors++;
         $display("FAIL reset state: got state=%0d IRWrite=%b PCWrite=%b ALUSrcB=%b expected 0,0,0,01",
                  state, IRWrite, PCWrite, ALUSrcB);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      opcode = 6'($urandom);
      // first instruction after release runs from the FETCH that is visible now
      instr_op = dir_ops.pop_front();
      push_lit(instr_op);
      rst_exec_pending = 1'b1;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         step();
         if (dir_ops.size() == 0 && lit_seq.size() == 0) begin
            if (rst) begin
               if ($urandom_range(0, 1) == 0) rst = 1'b0;
            end else if ((rst_exec_pending && exp_state == 4'd6) || $urandom_range(0, 49) == 0) begin
               #1 rst = 1'b1;
               rst_exec_pending = 1'b0;
               exp_state = 4'd0;
               path_q.delete();
            end
         end
      end
      @(negedge clk);
      checks++;
      if (rst_exec_pending) begin
         errors++;
         $display("FAIL reset during EXECUTE: got no EXECUTE visit expected one within budget");
      end
      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
